invader_formation: RTL

//  Parametrised ROWS x COLS invader grid controller; supersedes per-invader instances.

---
 rtl/invader_formation_if.sv | 40 ++++
 rtl/invader_formation.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/invader_formation_if.sv
// Bus between the invader formation controller and its neighbours: game control
// and shot inputs flow in, formation origin / alive map / hit report flow out.
// master = shot logic / game control side, slave = invader_formation.
interface invader_formation_if #(
   parameter int ROWS = 5,
   parameter int COLS = 10
);
   localparam int N  = ROWS * COLS;
   localparam int CW = $clog2(N + 1);
   localparam int IW = $clog2(N);

   logic          Restart;
   logic [9:0]    StartX;
   logic [9:0]    StartY;
   logic [9:0]    InvaderS;
   logic          ShotValid;
   logic [9:0]    ShotX;
   logic [9:0]    ShotY;
   logic [9:0]    ShotW;
   logic [9:0]    ShotH;
   logic [9:0]    FormX;
   logic [9:0]    FormY;
   logic [N-1:0]  Alive;
   logic [CW-1:0] AliveCount;
   logic          HitValid;
   logic [IW-1:0] HitIdx;
   logic          AllDead;

   modport master (
      output Restart, StartX, StartY, InvaderS,
      output ShotValid, ShotX, ShotY, ShotW, ShotH,
      input  FormX, FormY, Alive, AliveCount, HitValid, HitIdx, AllDead
   );

   modport slave (
      input  Restart, StartX, StartY, InvaderS,
      input  ShotValid, ShotX, ShotY, ShotW, ShotH,
      output FormX, FormY, Alive, AliveCount, HitValid, HitIdx, AllDead
   );
endinterface

// File: rtl/invader_formation.sv
// ROWS x COLS invader grid controller: alive bitmap, shared origin, left/right
// march with alive-count dependent speed, and single-kill-per-frame shot resolution.
// Optional feature macro: INVADER_DESCEND_EN (grid drops STEP_Y at each wall).
module invader_formation #(
   parameter int ROWS        = 5,
   parameter int COLS        = 10,
   parameter int CELL_W      = 25,
   parameter int CELL_H      = 20,
   parameter int STEP_X      = 15,
   parameter int STEP_Y      = 10,
   parameter int X_LEFT      = 0,
   parameter int X_RIGHT     = 639,
   parameter int DELAY_MIN   = 2,
   parameter int DELAY_SHIFT = 2
) (
   input logic                frame_clk,
   input logic                Reset,
   invader_formation_if.slave bus
);
   localparam int N    = ROWS * COLS;
   localparam int CW   = $clog2(N + 1);
   localparam int IW   = $clog2(N);
   localparam int COLW = $clog2(COLS + 1);
   // Edge and overlap arithmetic is widened past 10 bits so sums never wrap.
   localparam int EW   = 12;
   localparam int TW   = 16;

   typedef enum logic [1:0] {
      MARCH_R = 2'd0,
      MARCH_L = 2'd1,
`ifdef INVADER_DESCEND_EN
      DESCEND = 2'd2,
`endif
      HALT    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [9:0]      FormX_q, FormX_d;
   logic [9:0]      FormY_q, FormY_d;
   logic [N-1:0]    Alive_q, Alive_d;
   logic [CW-1:0]   AliveCount_q, AliveCount_d;
   logic            AllDead_q, AllDead_d;
   logic            HitValid_q, HitValid_d;
   logic [IW-1:0]   HitIdx_q, HitIdx_d;
   logic [TW-1:0]   counter_q, counter_d;
`ifdef INVADER_DESCEND_EN
   logic            dir_q, dir_d;     // 1: the march before DESCEND was rightward
`endif

   logic            rst_s;
   logic [COLS-1:0] col_alive_s;
   logic [COLW-1:0] first_col_s, last_col_s;
   logic [EW-1:0]   left_edge_s, right_edge_s;
   logic [TW-1:0]   delay_s;
   logic            step_s;
   logic [N-1:0]    hit_vec_s;
   logic            hit_found_s;
   logic [IW-1:0]   hit_idx_s;

   function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
      logic [CW-1:0] n;
      n = {CW{1'b0}};
      for (int i = 0; i < N; i++) begin
         n = n + {{(CW-1){1'b0}}, v[i]};
      end
      return n;
   endfunction

   // Does the sprite box of cell idx intersect the shot box (half-open, both non-empty)?
   function automatic logic cell_overlaps(input int idx, input logic [9:0] fx, input logic [9:0] fy,
                                          input logic [9:0] size, input logic [9:0] sx,
                                          input logic [9:0] sy, input logic [9:0] sw,
                                          input logic [9:0] sh);
      logic [EW-1:0] cx, cy;
      cx = EW'(fx) + EW'((idx % COLS) * CELL_W);
      cy = EW'(fy) + EW'((idx / COLS) * CELL_H);
      return (size != 10'd0) && (sw != 10'd0) && (sh != 10'd0)
          && (cx < EW'(sx) + EW'(sw)) && (EW'(sx) < cx + EW'(size))
          && (cy < EW'(sy) + EW'(sh)) && (EW'(sy) < cy + EW'(size));
   endfunction

   assign rst_s = Reset | bus.Restart;

   // Column occupancy and the first/last live column that set the march bounds.
   always_comb begin
      col_alive_s = {COLS{1'b0}};
      first_col_s = {COLW{1'b0}};
      last_col_s  = {COLW{1'b0}};
      for (int c = 0; c < COLS; c++) begin
         for (int r = 0; r < ROWS; r++) begin
            col_alive_s[c] = col_alive_s[c] | Alive_q[r*COLS + c];
         end
      end
      for (int c = COLS - 1; c >= 0; c--) begin
         first_col_s = col_alive_s[c] ? COLW'(c) : first_col_s;
      end
      for (int c = 0; c < COLS; c++) begin
         last_col_s = col_alive_s[c] ? COLW'(c) : last_col_s;
      end
      left_edge_s  = EW'(FormX_q) + EW'(int'(first_col_s) * CELL_W);
      right_edge_s = EW'(FormX_q) + EW'(int'(last_col_s) * CELL_W) + EW'(bus.InvaderS);
   end

   // Candidate cells for this frame's shot, against the pre-step origin.
   always_comb begin
      hit_vec_s = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         hit_vec_s[i] = bus.ShotValid & Alive_q[i]
                      & cell_overlaps(i, FormX_q, FormY_q, bus.InvaderS,
                                      bus.ShotX, bus.ShotY, bus.ShotW, bus.ShotH);
      end
   end

   // Lowest flat index among the candidates is the single kill.
   always_comb begin
      hit_found_s = |hit_vec_s;
      hit_idx_s   = {IW{1'b0}};
      for (int i = N - 1; i >= 0; i--) begin
         hit_idx_s = hit_vec_s[i] ? IW'(i) : hit_idx_s;
      end
   end

   // Step timer, march FSM and kill bookkeeping; bounds and delay use pre-kill Alive.
   always_comb begin
      state_d      = state_q;
      FormX_d      = FormX_q;
      FormY_d      = FormY_q;
      counter_d    = counter_q;
`ifdef INVADER_DESCEND_EN
      dir_d        = dir_q;
`endif
      delay_s      = TW'(DELAY_MIN) + TW'(AliveCount_q >> DELAY_SHIFT);
      step_s       = (counter_q >= delay_s);

      if (AllDead_q) begin
         state_d = HALT;
      end else begin
         counter_d = step_s ? {TW{1'b0}} : counter_q + {{(TW-1){1'b0}}, 1'b1};
         if (step_s) begin
            case (state_q)
               MARCH_R: begin
                  if (right_edge_s >= EW'(X_RIGHT)) begin
`ifdef INVADER_DESCEND_EN
                     dir_d   = 1'b1;
                     state_d = DESCEND;
`else
                     state_d = MARCH_L;
`endif
                  end else if (right_edge_s + EW'(STEP_X) <= EW'(X_RIGHT)) begin
                     FormX_d = FormX_q + 10'(STEP_X);
                  end else begin
                     FormX_d = FormX_q + 10'(EW'(X_RIGHT) - right_edge_s);
                  end
               end
               MARCH_L: begin
                  if (left_edge_s <= EW'(X_LEFT)) begin
`ifdef INVADER_DESCEND_EN
                     dir_d   = 1'b0;
                     state_d = DESCEND;
`else
                     state_d = MARCH_R;
`endif
                  end else if (left_edge_s >= EW'(X_LEFT + STEP_X)) begin
                     FormX_d = FormX_q - 10'(STEP_X);
                  end else begin
                     FormX_d = FormX_q - 10'(left_edge_s - EW'(X_LEFT));
                  end
               end
`ifdef INVADER_DESCEND_EN
               DESCEND: begin
                  FormY_d = FormY_q + 10'(STEP_Y);
                  state_d = dir_q ? MARCH_L : MARCH_R;
               end
`endif
               HALT: begin
                  state_d = HALT;
               end
               default: begin
                  state_d = MARCH_R;
               end
            endcase
         end else begin
            state_d = state_q;
         end
      end

      Alive_d      = hit_found_s ? (Alive_q & ~({{(N-1){1'b0}}, 1'b1} << hit_idx_s)) : Alive_q;
      AliveCount_d = popcount(Alive_d);
      AllDead_d    = (Alive_d == {N{1'b0}});
      HitValid_d   = hit_found_s;
      HitIdx_d     = hit_found_s ? hit_idx_s : HitIdx_q;
   end

   // State register; Reset or Restart wins over any pending hit or step.
   always_ff @(posedge frame_clk) begin
      if (rst_s) begin
         state_q      <= MARCH_R;
         FormX_q      <= bus.StartX;
         FormY_q      <= bus.StartY;
         Alive_q      <= {N{1'b1}};
         AliveCount_q <= CW'(N);
         AllDead_q    <= 1'b0;
         HitValid_q   <= 1'b0;
         HitIdx_q     <= {IW{1'b0}};
         counter_q    <= {TW{1'b0}};
`ifdef INVADER_DESCEND_EN
         dir_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         FormX_q      <= FormX_d;
         FormY_q      <= FormY_d;
         Alive_q      <= Alive_d;
         AliveCount_q <= AliveCount_d;
         AllDead_q    <= AllDead_d;
         HitValid_q   <= HitValid_d;
         HitIdx_q     <= HitIdx_d;
         counter_q    <= counter_d;
`ifdef INVADER_DESCEND_EN
         dir_q        <= dir_d;
`endif
      end
   end

   assign bus.FormX      = FormX_q;
   assign bus.FormY      = FormY_q;
   assign bus.Alive      = Alive_q;
   assign bus.AliveCount = AliveCount_q;
   assign bus.AllDead    = AllDead_q;
   assign bus.HitValid   = HitValid_q;
   assign bus.HitIdx     = HitIdx_q;
endmodule
